// File: rtl/packer_2to8_if.sv
// Symbol-in / byte-out bus of the 2-bit to 8-bit packer.
// master = producer/consumer side, slave = packer.
interface packer_2to8_if #(
   parameter int PTR_W = 2
);
   logic             valid_in;
   logic [1:0]       data_in;
   logic             pop;
   logic [7:0]       data_out;
   logic             empty;
   logic             full;
   logic [PTR_W:0]   count;
   logic             overflow;

   modport master (
      output valid_in, data_in, pop,
      input  data_out, empty, full, count, overflow
   );

   modport slave (
      input  valid_in, data_in, pop,
      output data_out, empty, full, count, overflow
   );
endinterface

// File: rtl/packer_2to8.sv
// Packs four valid 2-bit symbols (MSB first) into a byte and queues completed
// bytes in a small show-ahead FIFO drained by a pop strobe.
module packer_2to8 #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic          clk,
   input  logic          reset_L,
   packer_2to8_if.slave  bus
);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [1:0]       sym_cnt_reg;
   logic [7:0]       acc_reg;
   logic [7:0]       acc_next;
   logic [7:0]       mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             overflow_reg;

   logic             empty;
   logic             full;
   logic             push_req;
   logic             do_push;
   logic             do_pop;
   logic [7:0]       byte_next;
   logic [DEPTH-1:0] wr_en;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == FULL_CNT);
   assign push_req  = bus.valid_in && (sym_cnt_reg == 2'd3);
   assign byte_next = {acc_reg[7:2], bus.data_in};
   assign do_pop    = bus.pop && !empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign do_push   = push_req && (!full || do_pop);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   always_comb begin
      acc_next = acc_reg;
      case (sym_cnt_reg)
         2'd0:    acc_next[7:6] = bus.data_in;
         2'd1:    acc_next[5:4] = bus.data_in;
         2'd2:    acc_next[3:2] = bus.data_in;
         default: acc_next      = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         sym_cnt_reg  <= 2'd0;
         acc_reg      <= 8'h00;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (bus.valid_in) begin
            sym_cnt_reg <= sym_cnt_reg + 2'd1;
            acc_reg     <= acc_next;
         end
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (push_req && !do_push)
            overflow_reg <= 1'b1;
      end
   end

   // Register file carries no reset; validity is tracked by count_reg.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i])
            mem_reg[i] <= byte_next;
      end
   end

   assign bus.data_out = empty ? 8'h00 : mem_reg[rd_ptr_reg];
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.count    = count_reg;
   assign bus.overflow = overflow_reg;
endmodule

// File: doc/packer_2to8.md
Name: packer_2to8

Overview:
- Downstream stage of the 2-bit 2:1 mux: consumes its registered 2-bit `data_out` stream and packs four consecutive valid symbols into one byte.
- Completed bytes are buffered in a small show-ahead FIFO.
- A consumer drains the FIFO with a `pop` strobe.
- Sits between the mux and the byte-wide sink; verified against its synthesized netlist in a dual-instance bench like the mux.

Parameters:
DEPTH, 4, number of byte entries in the output FIFO (power of two)
PTR_W, 2, pointer width, log2(DEPTH)

Ports:
clk  input  1  single rising-edge clock
reset_L  input  1  synchronous active-low reset
valid_in  input  1  data_in carries a valid symbol this cycle
data_in  input  2  2-bit symbol from mux data_out
pop  input  1  consumer removes head byte at this edge
data_out  output  8  head-of-FIFO byte (show-ahead); 8'h00 when empty
empty  output  1  FIFO holds no bytes
full  output  1  FIFO holds DEPTH bytes
count  output  PTR_W+1  number of stored bytes, 0..DEPTH
overflow  output  1  sticky: a completed byte was dropped because FIFO was full

Behaviour:
- Reset: all state updates only on posedge clk.
  - When reset_L=0 at an edge: symbol counter=0, accumulator=0, wr/rd pointers=0, count=0, overflow=0.
  - Outputs after that edge: data_out=8'h00, empty=1, full=0.
  - Reset mid-byte discards the partial byte; reset overrides valid_in/pop.
- Packing, MSB first:
  - The first symbol of a group goes to byte[7:6], the second to [5:4], the third to [3:2], the fourth to [1:0].
  - The 2-bit symbol counter increments only on valid_in=1 and wraps 3->0.
  - valid_in=0 holds the counter and accumulator; gaps between symbols are allowed.
- Push: on the edge where valid_in=1 and the counter=3, the byte {acc[7:2], data_in} is written to the FIFO in that same edge.
  - No extra pipeline delay: the byte is visible on data_out one cycle after the 4th symbol is sampled, if the FIFO was empty.
- Pop: pop=1 with empty=0 advances the read pointer; data_out then shows the next entry or 8'h00.
  - pop=1 with empty=1 is ignored with no side effects.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - When full, a pop in the same cycle frees the slot, so the push succeeds and overflow is not set.
  - When empty, the pop is ignored and the push occurs, so count becomes 1.
- Overflow:
  - Push with full=1 and no pop: the byte is dropped, overflow=1 until reset, and pointers and count are unchanged.
  - The symbol counter still wraps to 0.
- Pointers wrap modulo DEPTH.
  - count = pushes - pops, never exceeding DEPTH.
  - full = (count==DEPTH) and empty = (count==0); both are derived from registered count, never combinationally from inputs.
- data_out is combinational from the register file at rd_ptr, gated to 0 when empty. Input data_in is not otherwise combinationally visible.
- Latency: 4th symbol edge to data_out valid is 1 cycle when the FIFO is empty.

Test Plan:
- Reset then idle: reset_L=0 for 2 cycles, release, valid_in=0 for 5 cycles -> data_out=8'h00, empty=1, full=0, count=0, overflow=0 throughout.
- Single byte: symbols 3,2,1,0 on consecutive cycles -> next cycle data_out=8'hE4, count=1, empty=0; pop=1 one cycle -> data_out=8'h00, empty=1.
- Gapped input: symbols 1,_,2,_,_,3,0 (_ = valid_in=0) -> one byte 8'h6C pushed only after the 4th valid symbol; count stays 0 until then.
- Fill and overflow: push bytes 8'h1B, 8'h27, 8'hE4, 8'hFF, then a fifth 8'h55 with pop=0 -> full=1, count=4, overflow=1, and pops return 1B, 27, E4, FF then empty=1 (55 absent).
- Full with simultaneous push/pop: FIFO full with 1B,27,E4,FF; pop=1 on the 4th-symbol edge of 8'hAA -> count stays 4, overflow=0, pops return 27, E4, FF, AA.
- Reset mid-byte: symbols 3,3, then reset_L=0 one cycle, then symbols 0,0,0,1 -> single byte 8'h01, count=1 (partial 3,3 discarded).
